// File: rtl/mrd_pkg.sv
// Shared widths, limits and FSM state encoding for the mixed-radix DFT source reader.
package mrd_pkg;
  localparam int N_BANKS     = 7;
  localparam int W_DATA      = 18;
  localparam int W_BANK_ADDR = 8;
  localparam int W_PTS       = 12;
  localparam int W_K         = 11;
  localparam int MAX_PTS     = 1200;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;
endpackage

// File: rtl/mrd_src_fifo.sv
// Synchronous output buffer with occupancy count; head reads as zero when empty.
module mrd_src_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNTW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic [CNTW-1:0]  o_count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CNTW-1:0]  r_count;
  logic             w_wr_en;
  logic             w_rd_en;

  assign w_wr_en = i_push && (r_count != CNTW'(DEPTH));
  assign w_rd_en = i_pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_en) r_wr <= (r_wr == AW'(DEPTH - 1)) ? '0 : r_wr + AW'(1);
      if (w_rd_en) r_rd <= (r_rd == AW'(DEPTH - 1)) ? '0 : r_rd + AW'(1);
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = o_empty ? '0 : r_mem[r_rd];
endmodule

// File: rtl/mrd_source_rd.sv
// Streams a frame out of the 7 interleaved result banks (sample k at bank k%7, addr k/7).
// state | meaning: IDLE wait for start | READ issue bank reads under credit | DRAIN wait for eop transfer
module mrd_source_rd
  import mrd_pkg::*;
#(
  parameter int RAM_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  i_start,
  input  logic [W_PTS-1:0]                      i_dftpts,
  output logic [N_BANKS-1:0]                    o_ram_rden,
  output logic [N_BANKS-1:0][W_BANK_ADDR-1:0]   o_ram_rdaddr,
  input  logic [N_BANKS-1:0][W_DATA-1:0]        i_ram_dout_real,
  input  logic [N_BANKS-1:0][W_DATA-1:0]        i_ram_dout_imag,
  output logic                                  o_out_valid,
  input  logic                                  i_out_ready,
  output logic                                  o_out_sop,
  output logic                                  o_out_eop,
  output logic [W_DATA-1:0]                     o_out_real,
  output logic [W_DATA-1:0]                     o_out_imag,
  output logic [W_PTS-1:0]                      o_out_dftpts,
  output logic                                  o_source_ongoing,
  output logic                                  o_done
);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int CW  = $clog2(FIFO_DEPTH + RAM_LAT + 1) + 1;
  localparam int FW  = 2 * W_DATA + 2;

  state_e                               r_state;
  logic [W_K-1:0]                       r_k;
  logic [2:0]                           r_bi;
  logic [W_BANK_ADDR-1:0]               r_ba;
  logic [W_PTS-1:0]                     r_dftpts;
  logic [N_BANKS-1:0][W_BANK_ADDR-1:0]  r_rdaddr;
  logic [RAM_LAT-1:0]                   r_pv;
  logic [RAM_LAT-1:0]                   r_pfirst;
  logic [RAM_LAT-1:0]                   r_plast;
  logic [RAM_LAT-1:0][2:0]              r_pbi;

  logic [CW-1:0]  w_in_flight;
  logic [FCW-1:0] w_fifo_count;
  logic           w_fifo_empty;
  logic           w_issue;
  logic           w_k_last;
  logic           w_push;
  logic [FW-1:0]  w_push_data;
  logic [FW-1:0]  w_head;
  logic           w_pop;
  logic           w_done;

  always_comb begin
    w_in_flight = '0;
    for (int i = 0; i < RAM_LAT; i++) w_in_flight = w_in_flight + CW'(r_pv[i]);
  end

  // Reads in flight already own a FIFO slot, so the buffer can never overflow.
  assign w_issue  = (r_state == ST_READ) &&
                    ((CW'(w_fifo_count) + w_in_flight) < CW'(FIFO_DEPTH));
  assign w_k_last = ({1'b0, r_k} == (r_dftpts - W_PTS'(1)));

  always_comb begin
    o_ram_rden   = '0;
    o_ram_rdaddr = r_rdaddr;
    if (w_issue) begin
      o_ram_rden[r_bi]   = 1'b1;
      o_ram_rdaddr[r_bi] = r_ba;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_k      <= '0;
      r_bi     <= '0;
      r_ba     <= '0;
      r_dftpts <= '0;
      r_rdaddr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start && (i_dftpts != '0) && (i_dftpts <= W_PTS'(MAX_PTS))) begin
            r_dftpts <= i_dftpts;
            r_k      <= '0;
            r_bi     <= '0;
            r_ba     <= '0;
            r_state  <= ST_READ;
          end
        end
        ST_READ: begin
          if (w_issue) begin
            r_rdaddr[r_bi] <= r_ba;
            r_k            <= r_k + W_K'(1);
            if (r_bi == 3'd6) begin
              r_bi <= '0;
              r_ba <= r_ba + W_BANK_ADDR'(1);
            end else begin
              r_bi <= r_bi + 3'd1;
            end
            if (w_k_last) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: if (w_done) r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pv     <= '0;
      r_pfirst <= '0;
      r_plast  <= '0;
      r_pbi    <= '0;
    end else begin
      r_pv[0]     <= w_issue;
      r_pfirst[0] <= (r_k == '0);
      r_plast[0]  <= w_k_last;
      r_pbi[0]    <= r_bi;
      for (int i = 1; i < RAM_LAT; i++) begin
        r_pv[i]     <= r_pv[i-1];
        r_pfirst[i] <= r_pfirst[i-1];
        r_plast[i]  <= r_plast[i-1];
        r_pbi[i]    <= r_pbi[i-1];
      end
    end
  end

  assign w_push      = r_pv[RAM_LAT-1];
  assign w_push_data = {r_pfirst[RAM_LAT-1], r_plast[RAM_LAT-1],
                        i_ram_dout_real[r_pbi[RAM_LAT-1]],
                        i_ram_dout_imag[r_pbi[RAM_LAT-1]]};

  mrd_src_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign o_out_valid = !w_fifo_empty;
  assign w_pop       = o_out_valid && i_out_ready;
  assign {o_out_sop, o_out_eop, o_out_real, o_out_imag} = w_head;
  assign w_done           = w_pop && o_out_eop && (r_state == ST_DRAIN);
  assign o_done           = w_done;
  assign o_out_dftpts     = r_dftpts;
  assign o_source_ongoing = (r_state != ST_IDLE);
endmodule

// File: tb/tb_mrd_source_rd.sv
// Scoreboard bench for mrd_source_rd: banks hold 7*addr+bank, so sample k carries value k.
module tb_mrd_source_rd;
  import mrd_pkg::*;

  localparam int RAM_LAT    = 1;
  localparam int FIFO_DEPTH = 4;

  logic                                 clk = 1'b0;
  logic                                 rst_n = 1'b0;
  logic                                 i_start = 1'b0;
  logic [W_PTS-1:0]                     i_dftpts = '0;
  logic [N_BANKS-1:0]                   o_ram_rden;
  logic [N_BANKS-1:0][W_BANK_ADDR-1:0]  o_ram_rdaddr;
  logic [N_BANKS-1:0][W_DATA-1:0]       dout_r = '0;
  logic [N_BANKS-1:0][W_DATA-1:0]       dout_i = '0;
  logic                                 o_out_valid;
  logic                                 i_out_ready = 1'b1;
  logic                                 o_out_sop, o_out_eop;
  logic [W_DATA-1:0]                    o_out_real, o_out_imag;
  logic [W_PTS-1:0]                     o_out_dftpts;
  logic                                 o_source_ongoing, o_done;
  logic [115:0]                         all_out;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          sop;
    bit          eop;
    logic [17:0] re;
    logic [17:0] im;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mrd_source_rd #(.RAM_LAT(RAM_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_start          (i_start),
    .i_dftpts         (i_dftpts),
    .o_ram_rden       (o_ram_rden),
    .o_ram_rdaddr     (o_ram_rdaddr),
    .i_ram_dout_real  (dout_r),
    .i_ram_dout_imag  (dout_i),
    .o_out_valid      (o_out_valid),
    .i_out_ready      (i_out_ready),
    .o_out_sop        (o_out_sop),
    .o_out_eop        (o_out_eop),
    .o_out_real       (o_out_real),
    .o_out_imag       (o_out_imag),
    .o_out_dftpts     (o_out_dftpts),
    .o_source_ongoing (o_source_ongoing),
    .o_done           (o_done)
  );

  assign all_out = {o_ram_rden, o_ram_rdaddr, o_out_valid, o_out_sop, o_out_eop,
                    o_out_real, o_out_imag, o_out_dftpts, o_source_ongoing, o_done};

  // One-cycle-latency bank RAMs
  always @(posedge clk) begin
    for (int b = 0; b < N_BANKS; b++) begin
      if (o_ram_rden[b]) begin
        dout_r[b] <= 18'(7 * int'(o_ram_rdaddr[b]) + b);
        dout_i[b] <= 18'(7 * int'(o_ram_rdaddr[b]) + b) ^ 18'h2AAAA;
      end
    end
  end

  // rmode 0: ready always high; 1: one cycle high, two low.
  task automatic run_frame(input int npts, input int rmode, input int extra_cyc,
                           input int abort_at, input bit tchk,
                           output int last_bi, output int last_ba);
    int cyc, issued, popped, ebi;
    bit fin, aborted, prev_stall;
    logic [37:0] prev_out;
    exp_t e;
    sb.delete();
    for (int k = 0; k < npts; k++) begin
      e.sop = (k == 0);
      e.eop = (k == npts - 1);
      e.re  = 18'(k);
      e.im  = 18'(k) ^ 18'h2AAAA;
      sb.push_back(e);
    end
    @(negedge clk);
    i_start = 1'b1; i_dftpts = 12'(npts); i_out_ready = 1'b1;
    cyc = 0; issued = 0; popped = 0; fin = 0; aborted = 0; prev_stall = 0;
    last_bi = -1; last_ba = -1; prev_out = '0;
    while (!fin && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      i_start     = (cyc == extra_cyc);
      i_dftpts    = 12'd20;
      i_out_ready = (rmode == 0) ? 1'b1 : ((cyc % 3) == 0);
      #1;
      if (o_ram_rden != '0) begin
        ebi = issued % 7;
        checks++;
        if (o_ram_rden !== 7'(1 << ebi) || o_ram_rdaddr[ebi] !== 8'(issued / 7)) begin
          failures++;
          $display("FAIL rd_issue k=%0d got rden=%b addr=%0d want rden=%b addr=%0d",
                   issued, o_ram_rden, o_ram_rdaddr[ebi], 7'(1 << ebi), issued / 7);
        end
        if (tchk && issued == 0) begin
          checks++;
          if (cyc != 1) begin
            failures++;
            $display("FAIL first_rden_cycle got %0d want 1", cyc);
          end
        end
        for (int b = 0; b < N_BANKS; b++)
          if (o_ram_rden[b]) begin last_bi = b; last_ba = int'(o_ram_rdaddr[b]); end
        issued++;
        checks++;
        if (issued - popped > FIFO_DEPTH || issued > npts) begin
          failures++;
          $display("FAIL credit issued=%0d popped=%0d depth=%0d npts=%0d",
                   issued, popped, FIFO_DEPTH, npts);
        end
      end
      if (prev_stall) begin
        checks++;
        if (!o_out_valid || {o_out_sop, o_out_eop, o_out_real, o_out_imag} !== prev_out) begin
          failures++;
          $display("FAIL stall_hold got valid=%b data=%h want valid=1 data=%h", o_out_valid,
                   {o_out_sop, o_out_eop, o_out_real, o_out_imag}, prev_out);
        end
      end
      if (o_out_valid && i_out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL extra_sample got re=%0d want no sample", o_out_real);
        end else begin
          e = sb.pop_front();
          if (o_out_sop !== e.sop || o_out_eop !== e.eop || o_out_real !== e.re ||
              o_out_imag !== e.im) begin
            failures++;
            $display("FAIL sample k=%0d got sop=%b eop=%b re=%0d im=%h want sop=%b eop=%b re=%0d im=%h",
                     popped, o_out_sop, o_out_eop, o_out_real, o_out_imag, e.sop, e.eop, e.re, e.im);
          end
          if (tchk) begin
            checks++;
            if (cyc != 3 + popped) begin
              failures++;
              $display("FAIL sample_cycle k=%0d got %0d want %0d", popped, cyc, 3 + popped);
            end
          end
          checks++;
          if (o_done !== e.eop) begin
            failures++;
            $display("FAIL done_at_transfer k=%0d got %b want %b", popped, o_done, e.eop);
          end
          checks++;
          if (o_out_dftpts !== 12'(npts) || o_source_ongoing !== 1'b1) begin
            failures++;
            $display("FAIL frame_status got dftpts=%0d ongoing=%b want dftpts=%0d ongoing=1",
                     o_out_dftpts, o_source_ongoing, npts);
          end
          if (e.eop) fin = 1;
        end
        popped++;
      end else begin
        checks++;
        if (o_done !== 1'b0) begin
          failures++;
          $display("FAIL spurious_done cycle=%0d got 1 want 0", cyc);
        end
      end
      prev_stall = o_out_valid && !i_out_ready;
      prev_out   = {o_out_sop, o_out_eop, o_out_real, o_out_imag};
      if (!fin && abort_at >= 0 && popped == abort_at) begin
        @(negedge clk);
        rst_n = 1'b0; i_out_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (all_out !== '0) begin
          failures++;
          $display("FAIL abort_outputs got %h want 0", all_out);
        end
        rst_n = 1'b1;
        repeat (8) begin
          @(negedge clk);
          #1;
          checks++;
          if (o_done !== 1'b0 || o_ram_rden !== '0 || o_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_quiet got done=%b rden=%b valid=%b want 0 0 0",
                     o_done, o_ram_rden, o_out_valid);
          end
        end
        fin = 1; aborted = 1;
      end
    end
    i_start = 1'b0;
    if (!fin) begin
      failures++;
      $display("FAIL timeout npts=%0d popped=%0d want %0d samples", npts, popped, npts);
    end else if (!aborted) begin
      checks++;
      if (popped != npts || sb.size() != 0) begin
        failures++;
        $display("FAIL sample_count got %0d want %0d", popped, npts);
      end
      @(negedge clk);
      #1;
      checks++;
      if (o_source_ongoing !== 1'b0 || o_out_valid !== 1'b0) begin
        failures++;
        $display("FAIL ongoing_fall got ongoing=%b valid=%b want 0 0", o_source_ongoing, o_out_valid);
      end
      repeat (3) begin
        @(negedge clk);
        #1;
        checks++;
        if (o_done !== 1'b0 || o_ram_rden !== '0) begin
          failures++;
          $display("FAIL post_frame got done=%b rden=%b want 0 0", o_done, o_ram_rden);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (all_out !== '0) begin
      failures++;
      $display("FAIL reset_outputs got %h want 0", all_out);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lb, la;
    run_frame(12, 0, -1, -1, 1'b1, lb, la);
    run_frame(1, 0, -1, -1, 1'b1, lb, la);
  endtask

  task automatic test_max_frame();
    int lb, la;
    run_frame(1200, 0, -1, -1, 1'b1, lb, la);
    checks++;
    if (lb != 1199 % 7 || la != 171) begin
      failures++;
      $display("FAIL last_read got bank=%0d addr=%0d want bank=%0d addr=171", lb, la, 1199 % 7);
    end
  endtask

  task automatic test_backpressure();
    int lb, la;
    run_frame(60, 1, -1, -1, 1'b0, lb, la);
  endtask

  task automatic test_ignored_starts();
    int lb, la;
    int bad_pts[2] = '{0, 1201};
    foreach (bad_pts[j]) begin
      @(negedge clk);
      i_start = 1'b1; i_dftpts = 12'(bad_pts[j]);
      @(negedge clk);
      i_start = 1'b0;
      repeat (3) begin
        @(negedge clk);
        #1;
        checks++;
        if (o_source_ongoing !== 1'b0 || o_ram_rden !== '0 || o_out_valid !== 1'b0) begin
          failures++;
          $display("FAIL bad_start pts=%0d got ongoing=%b rden=%b valid=%b want 0",
                   bad_pts[j], o_source_ongoing, o_ram_rden, o_out_valid);
        end
      end
    end
    run_frame(40, 0, 5, -1, 1'b1, lb, la);
  endtask

  task automatic test_abort();
    int lb, la;
    run_frame(96, 0, -1, 30, 1'b0, lb, la);
    run_frame(12, 0, -1, -1, 1'b1, lb, la);
  endtask

  task automatic test_back_to_back();
    int lb, la;
    run_frame(13, 0, -1, -1, 1'b1, lb, la);
    run_frame(7, 1, -1, -1, 1'b0, lb, la);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_frame();
    test_backpressure();
    test_ignored_starts();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
